// File: rtl/uart_cfg_pkg.sv
// Shared types, ASCII constants and helpers for the config-line generator.
// UART_CFG_MSG_CKSUM_EN selects the 11-byte line with an XOR checksum.
package uart_cfg_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_START,
      S_WAIT_HI,
      S_WAIT_LO,
      S_NEXT
   } state_t;

   localparam logic [7:0] C_CHR_C    = 8'h43;
   localparam logic [7:0] C_CHR_F    = 8'h46;
   localparam logic [7:0] C_CHR_G    = 8'h47;
   localparam logic [7:0] C_CHR_EQ   = 8'h3D;
   localparam logic [7:0] C_CHR_STAR = 8'h2A;
   localparam logic [7:0] C_CR       = 8'h0D;
   localparam logic [7:0] C_LF       = 8'h0A;

`ifdef UART_CFG_MSG_CKSUM_EN
   localparam int MSG_LEN = 11;
`else
   localparam int MSG_LEN = 8;
`endif

   localparam int IDX_W = 4;

   function automatic logic [7:0] nib2hex(input logic [3:0] n);
      return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
   endfunction

endpackage

// File: rtl/uart_cfg_period_tick.sv
// Free-running period counter; emits a one-cycle tick on each wrap.
// With PERIOD_TICKS=0 the counter is held at zero and tick never fires.
module uart_cfg_period_tick #(
   parameter int PERIOD_TICKS = 0,
   parameter int CNT_W        = 24
) (
   input  logic clk,
   input  logic rst_n,
   output logic tick
);

   localparam logic [CNT_W-1:0] LAST =
      CNT_W'((PERIOD_TICKS > 0) ? PERIOD_TICKS - 1 : 0);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (PERIOD_TICKS == 0 || cnt == LAST) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   assign tick = (PERIOD_TICKS != 0) && (cnt == LAST);

endmodule

// File: rtl/uart_cfg_msg_gen.sv
// Streams "CFG=HH\r\n" (or "CFG=HH*KK\r\n" with UART_CFG_MSG_CKSUM_EN)
// into uart_tx using the txStart/txBusy handshake.
module uart_cfg_msg_gen
   import uart_cfg_pkg::*;
#(
   parameter int PERIOD_TICKS = 0,
   parameter int BUSY_TO      = 4,
   parameter int CNT_W        = 24
) (
   input  logic       clkUtx,
   input  logic       rst_n,
   input  logic [7:0] cfgVal,
   input  logic       sendReq,
   input  logic       txBusy,
   output logic [7:0] txData8,
   output logic       txStart,
   output logic       msgBusy,
   output logic       msgDone
);

   localparam int TO_W = $clog2(BUSY_TO + 1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(BUSY_TO - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(MSG_LEN - 1);

   state_t state, state_nx;
   logic [IDX_W-1:0] idx;
   logic [TO_W-1:0] to_cnt;
   logic [7:0] cfg_reg;
   logic [7:0] cur_byte;
   logic [7:0] hex_hi, hex_lo;
   logic pending, tick, req, start, last;

   uart_cfg_period_tick #(
      .PERIOD_TICKS(PERIOD_TICKS),
      .CNT_W       (CNT_W)
   ) u_tick (
      .clk  (clkUtx),
      .rst_n(rst_n),
      .tick (tick)
   );

   assign req    = sendReq | tick;
   assign start  = req | pending;
   assign last   = (idx == IDX_LAST);
   assign hex_hi = nib2hex(cfg_reg[7:4]);
   assign hex_lo = nib2hex(cfg_reg[3:0]);

`ifdef UART_CFG_MSG_CKSUM_EN
   logic [7:0] cks;
   assign cks = C_CHR_C ^ C_CHR_F ^ C_CHR_G ^ C_CHR_EQ ^ hex_hi ^ hex_lo;
`endif

   always_comb begin
      cur_byte = C_LF;
      case (idx)
         4'd0: cur_byte = C_CHR_C;
         4'd1: cur_byte = C_CHR_F;
         4'd2: cur_byte = C_CHR_G;
         4'd3: cur_byte = C_CHR_EQ;
         4'd4: cur_byte = hex_hi;
         4'd5: cur_byte = hex_lo;
`ifdef UART_CFG_MSG_CKSUM_EN
         4'd6: cur_byte = C_CHR_STAR;
         4'd7: cur_byte = nib2hex(cks[7:4]);
         4'd8: cur_byte = nib2hex(cks[3:0]);
         4'd9: cur_byte = C_CR;
`else
         4'd6: cur_byte = C_CR;
`endif
         default: cur_byte = C_LF;
      endcase
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         S_IDLE:    if (start) state_nx = S_LOAD;
         S_LOAD:    state_nx = S_START;
         S_START:   state_nx = S_WAIT_HI;
         S_WAIT_HI: if (txBusy || to_cnt == TO_LAST) state_nx = S_WAIT_LO;
         S_WAIT_LO: if (!txBusy) state_nx = S_NEXT;
         S_NEXT:    state_nx = last ? S_IDLE : S_LOAD;
         default:   state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clkUtx or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         idx     <= '0;
         to_cnt  <= '0;
         cfg_reg <= '0;
         txData8 <= '0;
         pending <= 1'b0;
      end else begin
         state  <= state_nx;
         to_cnt <= (state == S_WAIT_HI) ? to_cnt + 1'b1 : '0;
         if (state == S_IDLE && start) begin
            cfg_reg <= cfgVal;
            idx     <= '0;
         end
         if (state == S_LOAD) txData8 <= cur_byte;
         if (state == S_NEXT && !last) idx <= idx + 1'b1;
         // one-deep: any number of requests during a line collapse to one
         if (state != S_IDLE) begin
            if (req) pending <= 1'b1;
         end else begin
            pending <= 1'b0;
         end
      end
   end

   assign txStart = (state == S_START);
   assign msgBusy = (state != S_IDLE);
   assign msgDone = (state == S_NEXT) && last;

endmodule
